// File: rtl/rtc_config_ctrl.sv
// Configuration UI sequencer for the clock: button pulses -> mode/cursor/blink and RTC strobes.
// Optional inactivity auto-exit is built only when RTC_CFG_TIMEOUT_EN is defined.
module rtc_config_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BLINK_HZ  = 2,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_cfg,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] config_mode,
    output logic [1:0] cursor_location,
    output logic       parpadeo,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       commit_pulse,
    output logic [1:0] commit_mode
);

    localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLINK_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(HALF - 1);

`ifdef RTC_CFG_TIMEOUT_EN
    localparam longint TO_CYCLES = longint'(TIMEOUT_S) * longint'(CLK_HZ);
    localparam int     TO_W      = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        HORA   = 2'd1,
        FECHA  = 2'd2,
        TIMER  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         cursor_q, cursor_d;
    logic               par_q, par_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               inc_q, inc_d;
    logic               dec_q, dec_d;
    logic               commit_q, commit_d;
    logic [1:0]         cmode_q, cmode_d;
    logic [1:0]         cur_max;
`ifdef RTC_CFG_TIMEOUT_EN
    logic [TO_W-1:0]    idle_q, idle_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= NORMAL;
            cursor_q <= 2'd0;
            par_q    <= 1'b0;
            blink_q  <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            commit_q <= 1'b0;
            cmode_q  <= 2'd0;
`ifdef RTC_CFG_TIMEOUT_EN
            idle_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            par_q    <= par_d;
            blink_q  <= blink_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            commit_q <= commit_d;
            cmode_q  <= cmode_d;
`ifdef RTC_CFG_TIMEOUT_EN
            idle_q   <= idle_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        par_d    = par_q;
        blink_d  = blink_q;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        commit_d = 1'b0;
        cmode_d  = cmode_q;
        cur_max  = (state_q == HORA) ? 2'd3 : 2'd2;
`ifdef RTC_CFG_TIMEOUT_EN
        idle_d   = '0;
`endif

        if (btn_cfg) begin
            if (state_q != NORMAL) begin
                commit_d = 1'b1;
                cmode_d  = state_q;
            end
            state_d  = state_t'(state_q + 2'd1);
            cursor_d = (state_d == NORMAL) ? 2'd0 : 2'd2;
            par_d    = (state_d != NORMAL);
            blink_d  = '0;
        end else if (state_q != NORMAL) begin
            // Any accepted edit restarts the blink so the cursor is shown at once
            if (btn_left || btn_right || btn_up || btn_down) begin
                par_d   = 1'b1;
                blink_d = '0;
                if (btn_left)
                    cursor_d = (cursor_q == cur_max) ? 2'd0 : cursor_q + 2'd1;
                else if (btn_right)
                    cursor_d = (cursor_q == 2'd0) ? cur_max : cursor_q - 2'd1;
                else if (btn_up)
                    inc_d = 1'b1;
                else
                    dec_d = 1'b1;
            end else begin
                if (blink_q == BLINK_LAST) begin
                    blink_d = '0;
                    par_d   = ~par_q;
                end else begin
                    blink_d = blink_q + BLINK_W'(1);
                end
`ifdef RTC_CFG_TIMEOUT_EN
                if (idle_q == TO_LAST) begin
                    state_d  = NORMAL;
                    commit_d = 1'b1;
                    cmode_d  = state_q;
                    cursor_d = 2'd0;
                    par_d    = 1'b0;
                    blink_d  = '0;
                end else begin
                    idle_d = idle_q + TO_W'(1);
                end
`endif
            end
        end
    end

    assign config_mode     = state_q;
    assign cursor_location = cursor_q;
    assign parpadeo        = par_q;
    assign inc_pulse       = inc_q;
    assign dec_pulse       = dec_q;
    assign commit_pulse    = commit_q;
    assign commit_mode     = cmode_q;

endmodule
